edp_slice_gen: RTL and testbench

Parametrised execution data-path slice: the successor to the fixed 6-bit EDP slices. Provides WIDTH bits of AR, ARX, BR and MQ, a boolean/arithmetic adder with carry chain, a parity-protected fast-memory (FM) array, and a registered EBUS diagnostic read port. It also adds a self-sequenced shift-and-add multiply step engine that the fixed slices lack. One instance covers a full word, or slices are cascaded through the carry pins.

---
 rtl/edp_slice_gen.sv | 160 ++++++++++++++++
 tb/tb_edp_slice_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/edp_slice_gen.sv
// Parametrised EDP slice: AR/ARX/BR/MQ, adder, parity FM, EBUS port
// and a shift-and-add multiply step engine.
module edp_slice_gen #(
    parameter int WIDTH     = 6,
    parameter int FM_BLOCKS = 8,
    parameter int BW        = (FM_BLOCKS > 1) ? $clog2(FM_BLOCKS) : 1
) (
    input  logic             clk_edp_h,
    input  logic             mr_reset_l,
    input  logic [2:0]       ad_sel_h,
    input  logic             ad_cry_in_h,
    input  logic             adb_sel_h,
    input  logic             ar_load_h,
    input  logic [1:0]       ar_sel_h,
    input  logic             arx_load_h,
    input  logic [1:0]       arx_sel_h,
    input  logic             br_load_h,
    input  logic             mq_load_h,
    input  logic [WIDTH-1:0] cache_data_h,
    input  logic [WIDTH-1:0] sh_h,
    input  logic             fm_write_l,
    input  logic [BW-1:0]    fm_block_h,
    input  logic [3:0]       fm_adr_h,
    input  logic             diag_force_par_err_h,
    input  logic             mul_start_h,
    input  logic             diag_read_h,
    input  logic [1:0]       diag_sel_h,
    output logic [WIDTH-1:0] ar_h,
    output logic [WIDTH-1:0] arx_h,
    output logic [WIDTH-1:0] br_h,
    output logic [WIDTH-1:0] mq_h,
    output logic [WIDTH-1:0] ad_h,
    output logic             ad_cry_out_h,
    output logic             ad_eq0_l,
    output logic [WIDTH-1:0] fm_data_h,
    output logic             fm_parity_err_h,
    output logic             mul_busy_h,
    output logic             mul_done_h,
    output logic [WIDTH-1:0] ebus_d_h,
    output logic             ebus_valid_h
);

    localparam int DEPTH = FM_BLOCKS * 16;
    localparam int CW    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] fm_mem [DEPTH];
    logic [WIDTH:0] fm_rd;
    logic [BW+3:0] fm_addr;
    logic [WIDTH-1:0] b_op, b_eff, fm_word, src_ar, src_arx;
    logic [WIDTH:0] sum, mul_sum;
    logic locked;

    // Adder
    assign b_op  = adb_sel_h ? arx_h : br_h;
    assign b_eff = (ad_sel_h == 3'd1) ? ~b_op : b_op;
    assign sum   = {1'b0, ar_h} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ad_cry_in_h};

    always_comb begin
        ad_h         = '0;
        ad_cry_out_h = 1'b0;
        case (ad_sel_h)
            3'd0, 3'd1: begin
                ad_h         = sum[WIDTH-1:0];
                ad_cry_out_h = sum[WIDTH];
            end
            3'd2:    ad_h = ar_h & b_op;
            3'd3:    ad_h = ar_h | b_op;
            3'd4:    ad_h = ar_h ^ b_op;
            3'd5:    ad_h = ar_h;
            3'd6:    ad_h = b_op;
            default: ad_h = ~ar_h;
        endcase
    end

    assign ad_eq0_l = |ad_h;

    // FM array: data plus odd parity, contents survive reset
    assign fm_addr = {fm_block_h, fm_adr_h};
    assign fm_rd   = fm_mem[fm_addr];
    assign fm_word = fm_rd[WIDTH-1:0];

    always_ff @(posedge clk_edp_h) begin
        if (mr_reset_l && !fm_write_l)
            fm_mem[fm_addr] <= {(~^ar_h) ^ diag_force_par_err_h, ar_h};
    end

    always_comb begin
        case (ar_sel_h)
            2'd0:    src_ar = ad_h;
            2'd1:    src_ar = cache_data_h;
            2'd2:    src_ar = fm_word;
            default: src_ar = sh_h;
        endcase
        case (arx_sel_h)
            2'd0:    src_arx = ad_h;
            2'd1:    src_arx = cache_data_h;
            2'd2:    src_arx = fm_word;
            default: src_arx = sh_h;
        endcase
    end

    // Multiply sequencer
    assign locked  = (state != IDLE);
    assign mul_sum = mq_h[0] ? ({1'b0, ar_h} + {1'b0, br_h}) : {1'b0, ar_h};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_start_h) state_nxt = STEP;
            STEP:    if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mul_busy_h = (state == STEP);
    assign mul_done_h = (state == DONE);

    always_ff @(posedge clk_edp_h) begin
        if (!mr_reset_l) begin
            state           <= IDLE;
            cnt             <= '0;
            ar_h            <= '0;
            arx_h           <= '0;
            br_h            <= '0;
            mq_h            <= '0;
            fm_data_h       <= '0;
            fm_parity_err_h <= 1'b0;
            ebus_d_h        <= '0;
            ebus_valid_h    <= 1'b0;
        end else begin
            state           <= state_nxt;
            fm_data_h       <= fm_word;
            fm_parity_err_h <= ~^fm_rd;
            ebus_valid_h    <= diag_read_h;
            if (!diag_read_h) ebus_d_h <= '0;
            else case (diag_sel_h)
                2'd0:    ebus_d_h <= ar_h;
                2'd1:    ebus_d_h <= arx_h;
                2'd2:    ebus_d_h <= mq_h;
                default: ebus_d_h <= ad_h;
            endcase
            if (state == IDLE && mul_start_h) cnt <= '0;
            else if (state == STEP) cnt <= cnt + 1'b1;
            if (state == STEP) begin
                ar_h <= mul_sum[WIDTH:1];
                mq_h <= {mul_sum[0], mq_h[WIDTH-1:1]};
            end else if (!locked) begin
                if (ar_load_h) ar_h <= src_ar;
                if (mq_load_h) mq_h <= ad_h;
            end
            if (arx_load_h) arx_h <= src_arx;
            if (br_load_h)  br_h  <= ar_h;
        end
    end

endmodule

// File: tb/tb_edp_slice_gen.sv
// Directed self-checking bench for edp_slice_gen at WIDTH=6.
module tb_edp_slice_gen;

    localparam int W = 6;

    logic clk = 1'b0;
    logic rst_l;
    logic [2:0] ad_sel;
    logic cin, adb_sel, ar_load, arx_load, br_load, mq_load;
    logic [1:0] ar_sel, arx_sel, diag_sel;
    logic [W-1:0] cache_data, sh;
    logic fm_write_l, force_err, mul_start, diag_read;
    logic [2:0] fm_block;
    logic [3:0] fm_adr;
    logic [W-1:0] ar, arx, br, mq, ad, fm_data, ebus_d;
    logic cry_out, eq0_l, par_err, busy, done, ebus_valid;

    int checks = 0;
    int errors = 0;
    int n;
    bit saw_done;

    always #5 clk = ~clk;

    edp_slice_gen #(.WIDTH(W), .FM_BLOCKS(8)) dut (
        .clk_edp_h(clk), .mr_reset_l(rst_l),
        .ad_sel_h(ad_sel), .ad_cry_in_h(cin), .adb_sel_h(adb_sel),
        .ar_load_h(ar_load), .ar_sel_h(ar_sel),
        .arx_load_h(arx_load), .arx_sel_h(arx_sel),
        .br_load_h(br_load), .mq_load_h(mq_load),
        .cache_data_h(cache_data), .sh_h(sh),
        .fm_write_l(fm_write_l), .fm_block_h(fm_block), .fm_adr_h(fm_adr),
        .diag_force_par_err_h(force_err), .mul_start_h(mul_start),
        .diag_read_h(diag_read), .diag_sel_h(diag_sel),
        .ar_h(ar), .arx_h(arx), .br_h(br), .mq_h(mq), .ad_h(ad),
        .ad_cry_out_h(cry_out), .ad_eq0_l(eq0_l),
        .fm_data_h(fm_data), .fm_parity_err_h(par_err),
        .mul_busy_h(busy), .mul_done_h(done),
        .ebus_d_h(ebus_d), .ebus_valid_h(ebus_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_loads();
        ar_load = 0; arx_load = 0; br_load = 0; mq_load = 0;
    endtask

    initial begin
        rst_l = 0; ad_sel = 0; cin = 0; adb_sel = 0;
        ar_load = 0; arx_load = 0; br_load = 0; mq_load = 0;
        ar_sel = 2'd3; arx_sel = 2'd3; diag_sel = 0;
        cache_data = 0; sh = 0; fm_write_l = 1; force_err = 0;
        mul_start = 0; diag_read = 0; fm_block = 0; fm_adr = 0;
        step(); step();
        rst_l = 1;

        // Reset: fill registers with 0x3F then reset with loads still on
        sh = 6'h3F; ar_load = 1; arx_load = 1;
        step();
        ad_sel = 3'd5; br_load = 1; mq_load = 1; diag_read = 1;
        step();
        check("pre_rst_mq", mq, 6'h3F);
        rst_l = 0;
        step();
        rst_l = 1; clr_loads(); diag_read = 0;
        check("rst_ar", ar, 0);
        check("rst_arx", arx, 0);
        check("rst_br", br, 0);
        check("rst_mq", mq, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ebus_v", ebus_valid, 0);
        check("rst_ebus_d", ebus_d, 0);
        check("rst_fm_data", fm_data, 0);
        check("rst_par_err", par_err, 0);

        // Adder: AR=0x3F, BR=0x01
        sh = 6'h01; ar_load = 1;
        step();
        sh = 6'h3F; br_load = 1;
        step();
        clr_loads();
        ad_sel = 3'd0; cin = 0; adb_sel = 0; #1;
        check("add_ad", ad, 6'h00);
        check("add_cry", cry_out, 1);
        check("add_eq0_l", eq0_l, 0);
        ad_sel = 3'd1; cin = 1; #1;
        check("sub_ad", ad, 6'h3E);
        check("sub_cry", cry_out, 1);
        check("sub_eq0_l", eq0_l, 1);
        ad_sel = 3'd4; cin = 0; #1;
        check("xor_ad", ad, 6'h3E);
        check("xor_cry", cry_out, 0);
        ad_sel = 3'd7; #1;
        check("not_ad", ad, 6'h00);
        ad_sel = 3'd2; #1;
        check("and_ad", ad, 6'h01);

        // FM write/read with parity
        sh = 6'h2A; ar_load = 1;
        step();
        ar_load = 0; fm_block = 3'd3; fm_adr = 4'd5; fm_write_l = 0;
        step();
        fm_write_l = 1;
        step();
        check("fm_data", fm_data, 6'h2A);
        check("fm_par_ok", par_err, 0);
        fm_write_l = 0; force_err = 1;
        step();
        fm_write_l = 1; force_err = 0;
        step();
        check("fm_data_f", fm_data, 6'h2A);
        check("fm_par_bad", par_err, 1);
        sh = 6'h15; ar_load = 1;
        step();
        ar_load = 0; fm_write_l = 0;
        step();
        fm_write_l = 1;
        check("fm_rd_old", fm_data, 6'h2A);
        check("fm_rd_old_p", par_err, 1);
        step();
        check("fm_rd_new", fm_data, 6'h15);
        check("fm_rd_new_p", par_err, 0);

        // Multiply 45 * 27
        sh = 6'd45; ar_load = 1;
        step();
        ad_sel = 3'd5; mq_load = 1; sh = 6'd27;
        step();
        mq_load = 0; br_load = 1; sh = 6'd0;
        step();
        clr_loads();
        check("mul_pre_mq", mq, 6'd45);
        check("mul_pre_br", br, 6'd27);
        check("mul_pre_ar", ar, 6'd0);
        mul_start = 1;
        step();
        mul_start = 0;
        n = busy ? 1 : 0;
        ar_load = 1; sh = 6'h3F; mul_start = 1; mq_load = 1;
        step();
        ar_load = 0; mul_start = 0; mq_load = 0;
        if (busy) n++;
        for (int i = 0; i < 20 && busy; i++) begin
            step();
            if (busy) n++;
        end
        check("mul_busy_cyc", n, 6);
        check("mul_done", done, 1);
        check("mul_ar", ar, 6'd18);
        check("mul_mq", mq, 6'd63);
        check("mul_br", br, 6'd27);
        step();
        check("mul_done_1cyc", done, 0);
        check("mul_no_restart", busy, 0);

        // Reset mid-multiply
        mul_start = 1;
        step();
        mul_start = 0;
        step(); step(); step();
        check("abort_busy_pre", busy, 1);
        rst_l = 0;
        step();
        rst_l = 1;
        check("abort_busy", busy, 0);
        check("abort_ar", ar, 0);
        check("abort_mq", mq, 0);
        saw_done = done;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done || busy) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);

        // EBUS
        sh = 6'h15; ar_load = 1;
        step();
        ar_load = 0; ad_sel = 3'd5; mq_load = 1;
        step();
        mq_load = 0; diag_read = 1; diag_sel = 2'd2;
        step();
        check("ebus_mq", ebus_d, 6'h15);
        check("ebus_v", ebus_valid, 1);
        diag_sel = 2'd3; ad_sel = 3'd7;
        step();
        check("ebus_ad", ebus_d, 6'h2A);
        check("ebus_v2", ebus_valid, 1);
        diag_read = 0;
        step();
        check("ebus_idle_d", ebus_d, 0);
        check("ebus_idle_v", ebus_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
